// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the scroller and the scan stage.
// Character codes: 0-9 digits, 10-35 letters A-Z, 36 blank, 37 dash,
// 38-63 blank. Glyph bytes are abcdefgh, active-low (0 = segment lit).
package seg7_pkg;

  localparam logic [5:0]  CH_BLANK     = 6'd36;
  localparam logic [5:0]  CH_DASH      = 6'd37;
  localparam logic [7:0]  GLYPH_BLANK  = 8'hFF;
  localparam logic [7:0]  GLYPH_DASH   = 8'hFD;
  localparam logic [31:0] GLYPHS_BLANK = {4{GLYPH_BLANK}};

  typedef enum logic {
    ST_IDLE,
    ST_SCROLL
  } scroll_state_t;

  // K, M, V, W and X have no true seven-segment form; the bytes used for
  // them are fixed approximations.
  function automatic logic [7:0] char_to_glyph(input logic [5:0] code);
    logic [7:0] g;
    case (code)
      6'd0:    g = 8'h03;
      6'd1:    g = 8'h9F;
      6'd2:    g = 8'h25;
      6'd3:    g = 8'h0D;
      6'd4:    g = 8'h99;
      6'd5:    g = 8'h49;
      6'd6:    g = 8'h41;
      6'd7:    g = 8'h1F;
      6'd8:    g = 8'h01;
      6'd9:    g = 8'h09;
      6'd10:   g = 8'h11; // A
      6'd11:   g = 8'hC1; // b
      6'd12:   g = 8'h63; // C
      6'd13:   g = 8'h85; // d
      6'd14:   g = 8'h61; // E
      6'd15:   g = 8'h71; // F
      6'd16:   g = 8'h43; // G
      6'd17:   g = 8'h91; // H
      6'd18:   g = 8'h9F; // I
      6'd19:   g = 8'h87; // J
      6'd20:   g = 8'h51; // K (approx)
      6'd21:   g = 8'hE3; // L
      6'd22:   g = 8'h55; // M (approx)
      6'd23:   g = 8'hD5; // n
      6'd24:   g = 8'hC5; // o
      6'd25:   g = 8'h31; // P
      6'd26:   g = 8'h19; // q
      6'd27:   g = 8'hF5; // r
      6'd28:   g = 8'h49; // S
      6'd29:   g = 8'hE1; // t
      6'd30:   g = 8'h83; // U
      6'd31:   g = 8'hC7; // V (approx)
      6'd32:   g = 8'hAB; // W (approx)
      6'd33:   g = 8'h93; // X (approx)
      6'd34:   g = 8'h89; // y
      6'd35:   g = 8'h25; // Z
      CH_DASH: g = GLYPH_DASH;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/word_scroller_if.sv
// Character load / control / display bus of word_scroller.
//   char_valid, char_code, char_ready : character handshake
//   clear, start, stop                : single-cycle control pulses
//   glyphs, busy                      : display output and scroll status
// master = feeder/controller side, slave = word_scroller.
interface word_scroller_if;
  logic        char_valid;
  logic [5:0]  char_code;
  logic        char_ready;
  logic        clear;
  logic        start;
  logic        stop;
  logic [31:0] glyphs;
  logic        busy;

  modport master (
    output char_valid, char_code, clear, start, stop,
    input  char_ready, glyphs, busy
  );

  modport slave (
    input  char_valid, char_code, clear, start, stop,
    output char_ready, glyphs, busy
  );
endinterface

// File: rtl/strobe_gen.sv
// Step strobe: counts 0..PERIOD-1 and flags the last count with tick, giving
// one single-cycle tick every PERIOD cycles. clr holds the count at zero.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous counter clear
//   tick       : high for one cycle every PERIOD cycles
module strobe_gen #(
  parameter int unsigned PERIOD = 8388608
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(PERIOD - 1));
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/word_scroller.sv
// Message buffer and right-to-left scroller feeding the 4-digit scan stage.
// Characters are loaded while idle; start scrolls the message (followed by
// four blanks) through a 4-digit window, one position per STEP_CYCLES.
//   clk, reset : clock, synchronous active-high reset
//   bus        : char handshake, clear/start/stop pulses, glyphs, busy
module word_scroller
  import seg7_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STEP_CYCLES = 8388608
) (
  input  logic            clk,
  input  logic            reset,
  word_scroller_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;  // count spans 0..DEPTH
  localparam int unsigned IW = CW + 1;  // p + 3 stays below 4*DEPTH

  scroll_state_t r_state;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_p;
  logic [5:0]    r_buf [DEPTH];
  logic [31:0]   r_glyphs;

  logic          w_ready;
  logic          w_wr;
  logic          w_tick;
  logic          w_strobe_clr;
  logic [IW-1:0] w_len;
  logic [IW-1:0] w_p_next;
  logic [31:0]   w_window;

  assign w_ready      = (r_state == ST_IDLE) && (r_count < CW'(DEPTH));
  assign w_wr         = bus.char_valid && w_ready;
  assign w_len        = IW'(r_count) + IW'(4);
  assign w_p_next     = (r_p + IW'(1) == w_len) ? '0 : r_p + IW'(1);
  assign w_strobe_clr = (r_state != ST_SCROLL);

  strobe_gen #(.PERIOD(STEP_CYCLES)) u_strobe (
    .clk   (clk),
    .reset (reset),
    .clr   (w_strobe_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_p     <= '0;
    end else if (bus.clear) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_p     <= '0;
    end else if (r_state == ST_SCROLL) begin
      if (bus.stop) begin
        r_state <= ST_IDLE;
        r_p     <= '0;
      end else if (w_tick) begin
        r_p <= w_p_next;
      end
    end else begin
      if (w_wr) begin
        r_count <= r_count + CW'(1);
      end
      // A same-cycle write counts toward a non-empty message.
      if (bus.start && !bus.stop && ((r_count != '0) || w_wr)) begin
        r_state <= ST_SCROLL;
        r_p     <= '0;
      end
    end
  end

  // No reset: entries at or above count are never displayed. A write
  // coinciding with clear lands here but is unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[r_count[AW-1:0]] <= bus.char_code;
    end
  end

  // Window over the virtual stream: message then four blanks, modulo L.
  always_comb begin
    logic [IW-1:0] idx;
    logic [5:0]    code;
    w_window = '1;
    idx      = '0;
    code     = CH_BLANK;
    for (int unsigned d = 0; d < 4; d++) begin
      idx = r_p + IW'(d);
      if (idx >= w_len) begin
        idx = idx - w_len;
      end
      code = (idx < IW'(r_count)) ? r_buf[idx[AW-1:0]] : CH_BLANK;
      w_window[31 - 8*d -: 8] = char_to_glyph(code);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_glyphs <= GLYPHS_BLANK;
    end else begin
      r_glyphs <= (r_state == ST_SCROLL) ? w_window : GLYPHS_BLANK;
    end
  end

  assign bus.char_ready = w_ready;
  assign bus.busy       = (r_state == ST_SCROLL);
  assign bus.glyphs     = r_glyphs;
endmodule

// File: tb/tb_word_scroller.sv
module tb_word_scroller;
  localparam int DEPTH = 16;
  localparam int STEP  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_scroller_if bus();

  word_scroller #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent glyph table for the codes this bench uses.
  function automatic logic [7:0] ref_glyph(input int c);
    case (c)
      0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
      4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
      8: return 8'h01;  9: return 8'h09; 10: return 8'h11; 11: return 8'hC1;
     12: return 8'h63; 13: return 8'h85; 14: return 8'h61; 15: return 8'h71;
     17: return 8'h91; 18: return 8'h9F; 37: return 8'hFD;
      default: return (c >= 36) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Behavioural model: message list, scroll flag, and the cycle busy rose;
  // the window position follows from elapsed cycles.
  bit          m_scroll = 0;
  int          m_count  = 0;
  int          m_rise   = 0;
  int          cyc      = 0;
  int          m_buf [DEPTH];
  logic [31:0] exp_glyphs = 32'hFFFF_FFFF;
  logic        exp_busy   = 1'b0;
  logic        exp_ready  = 1'b1;
  bit          check_en   = 0;

  function automatic logic [31:0] model_window(input int p);
    logic [31:0] w;
    int L, idx, c;
    L = m_count + 4;
    w = '1;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % L;
      c = (idx < m_count) ? m_buf[idx] : 36;
      w[31 - 8*k -: 8] = ref_glyph(c);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    int p;
    bit acc;
    p   = m_scroll ? ((cyc - m_rise) / STEP) % (m_count + 4) : 0;
    acc = bus.char_valid && !m_scroll && (m_count < DEPTH);
    exp_glyphs <= m_scroll ? model_window(p) : 32'hFFFF_FFFF;
    cyc <= cyc + 1;
    if (reset) begin
      m_scroll <= 0; m_count <= 0;
      exp_busy <= 1'b0; exp_ready <= 1'b1; exp_glyphs <= 32'hFFFF_FFFF;
    end else if (bus.clear) begin
      m_scroll <= 0; m_count <= 0;
      exp_busy <= 1'b0; exp_ready <= 1'b1;
    end else if (m_scroll) begin
      if (bus.stop) begin
        m_scroll  <= 0;
        exp_busy  <= 1'b0;
        exp_ready <= (m_count < DEPTH);
      end
    end else begin
      if (acc) m_buf[m_count] <= int'(bus.char_code);
      m_count <= m_count + (acc ? 1 : 0);
      if (bus.start && !bus.stop && (m_count > 0 || acc)) begin
        m_scroll  <= 1;
        m_rise    <= cyc + 1;
        exp_busy  <= 1'b1;
        exp_ready <= 1'b0;
      end else begin
        exp_ready <= ((m_count + (acc ? 1 : 0)) < DEPTH);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("glyphs", bus.glyphs, exp_glyphs);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("char_ready", 32'(bus.char_ready), 32'(exp_ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hi_exp [7] = '{32'h919F_FFFF, 32'h9FFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FF91, 32'hFFFF_919F, 32'hFF91_9FFF,
                              32'h919F_FFFF};

  initial begin
    int nacc;
    bus.char_valid = 1'b0; bus.char_code = '0;
    bus.clear = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check_en = 1;
    @(negedge clk);
    check("reset_glyphs", bus.glyphs, 32'hFFFF_FFFF);
    check("reset_ready", 32'(bus.char_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("model_reset", exp_glyphs, 32'hFFFF_FFFF);

    // H, I then start: one window every STEP cycles, wrapping at L=6.
    step(); bus.char_valid = 1'b1; bus.char_code = 6'd17;
    step(); bus.char_code = 6'd18;
    step(); bus.char_valid = 1'b0; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    @(negedge clk);
    check("hi_win0", bus.glyphs, hi_exp[0]);
    check("model_hi0", exp_glyphs, hi_exp[0]);
    for (int k = 1; k < 7; k++) begin
      repeat (STEP) step();
      @(negedge clk);
      check($sformatf("hi_win%0d", k), bus.glyphs, hi_exp[k]);
      check($sformatf("model_hi%0d", k), exp_glyphs, hi_exp[k]);
    end
    step(); bus.stop = 1'b1;
    step(); bus.stop = 1'b0;

    // Hold valid for 20 cycles: exactly DEPTH transfers.
    step(); bus.clear = 1'b1;
    step(); bus.clear = 1'b0;
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.char_valid = 1'b1;
      bus.char_code  = 6'(i % 16);
      @(negedge clk);
      if (bus.char_ready) nacc++;
      step();
    end
    bus.char_valid = 1'b0;
    check("transfers", 32'(nacc), 32'd16);
    @(negedge clk);
    check("ready_full", 32'(bus.char_ready), 32'd0);
    step(); bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    @(negedge clk);
    check("full_win0", bus.glyphs, 32'h039F_250D);
    repeat (20 * STEP + 4) step();
    bus.stop = 1'b1;
    step(); bus.stop = 1'b0;
    step(); step();

    // Stop at p=3, then restart from p=0 with the buffer intact.
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    repeat (12) step();
    bus.stop = 1'b1;
    @(negedge clk);
    check("stop_at_p3", bus.glyphs, 32'h0D99_4941);
    step(); bus.stop = 1'b0;
    @(negedge clk);
    check("stop_busy", 32'(bus.busy), 32'd0);
    step();
    @(negedge clk);
    check("stop_blank", bus.glyphs, 32'hFFFF_FFFF);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    @(negedge clk);
    check("restart_win0", bus.glyphs, 32'h039F_250D);
    check("restart_busy", 32'(bus.busy), 32'd1);
    step(); bus.stop = 1'b1;
    step(); bus.stop = 1'b0;

    // clear + start + write together: stays idle and empty.
    step();
    bus.clear = 1'b1; bus.start = 1'b1; bus.char_valid = 1'b1; bus.char_code = 6'd5;
    step();
    bus.clear = 1'b0; bus.start = 1'b0; bus.char_valid = 1'b0;
    @(negedge clk);
    check("csw_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    step();
    @(negedge clk);
    check("empty_start_busy", 32'(bus.busy), 32'd0);
    check("empty_start_glyphs", bus.glyphs, 32'hFFFF_FFFF);
    check("empty_ready", 32'(bus.char_ready), 32'd1);

    // Out-of-range codes and dash; last write coincides with start.
    bus.char_valid = 1'b1; bus.char_code = 6'd40;
    step(); bus.char_code = 6'd63;
    step(); bus.char_code = 6'd37; bus.start = 1'b1;
    step(); bus.char_valid = 1'b0; bus.start = 1'b0;
    step();
    @(negedge clk);
    check("codes_win0", bus.glyphs, 32'hFFFF_FDFF);
    repeat (7 * STEP) step();
    bus.stop = 1'b1;
    step(); bus.stop = 1'b0;
    step(); step();

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
